// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite fetch block.
// Optional feature macro used by the block: SPRITE_MIRROR_EN (horizontal mirror).
package sprite_pkg;

  // Default sprite geometry and ROM address width.
  localparam int unsigned SPR_W_DFLT  = 135;
  localparam int unsigned SPR_H_DFLT  = 40;
  localparam int unsigned ADDR_W_DFLT = 13;

  // Screen coordinate width is fixed by the VGA timing and shared by all clients.
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SCROLL_W = 8;

  typedef logic [COORD_W-1:0]  coord_t;
  // One extra bit so edge sums never wrap.
  typedef logic [COORD_W:0]    coord_ext_t;
  typedef logic [SCROLL_W-1:0] scroll_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pos_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } fsm_t;

  // Single conditional subtract; callers guarantee v < 2*m.
  function automatic coord_ext_t wrap_once(input coord_ext_t v, input coord_ext_t m);
    return (v >= m) ? (v - m) : v;
  endfunction

endpackage

// File: rtl/sprite_pos_latch.sv
// Position handshake and per-frame state for the sprite fetch block.
// Holds pending/active sprite position and the horizontal scroll offset; all
// active values only move on frame_start so a frame is never torn.
// Optional feature macro: SPRITE_MIRROR_EN adds a frame-latched mirror flag.
module sprite_pos_latch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W = SPR_W_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [COORD_W-1:0]  pos_x,
  input  logic [COORD_W-1:0]  pos_y,
  input  logic                pos_load,
  input  logic [SCROLL_W-1:0] scroll_step,
`ifdef SPRITE_MIRROR_EN
  input  logic                mirror,
  output logic                mirror_act,
`endif
  output logic                pos_ack,
  output pos_t                act_pos,
  output logic [SCROLL_W-1:0] scroll
);

  fsm_t    state;
  pos_t    pend_pos;
  scroll_t scroll_next;

  // Next scroll offset, kept in 0..SPR_W-1 because scroll_step < SPR_W.
  always_comb begin
    scroll_next = scroll_t'(wrap_once(coord_ext_t'(scroll) + coord_ext_t'(scroll_step),
                                      coord_ext_t'(SPR_W)));
  end

  // Handshake FSM with registered ack, pending/active position and scroll.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend_pos <= '0;
      act_pos  <= '0;
      scroll   <= '0;
      pos_ack  <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      mirror_act <= 1'b0;
`endif
    end else begin
      pos_ack <= pos_load;

      if (frame_start) begin
        scroll <= scroll_next;
`ifdef SPRITE_MIRROR_EN
        mirror_act <= mirror;
`endif
        // Only a position that was already pending is promoted; a load in this
        // same cycle waits for the next frame.
        if (state == PENDING) begin
          act_pos <= pend_pos;
        end
      end

      if (pos_load) begin
        pend_pos.x <= pos_x;
        pend_pos.y <= pos_y;
        state      <= PENDING;
      end else if (frame_start) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: rtl/sprite_fetch.sv
// Read-side client of a 1-bit sprite ROM with one cycle of registered read latency.
// Stage 0 hit-tests the scan coordinate and forms the ROM address (with scroll
// wrap), stage 1 registers the address, stage 2 realigns the returned ROM bit
// with the delayed coordinate. Scan coordinate to pixel_on latency is 2 cycles.
// Optional feature macro: SPRITE_MIRROR_EN adds the frame-latched mirror input.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W  = SPR_W_DFLT,
  parameter int unsigned SPR_H  = SPR_H_DFLT,
  parameter int unsigned ADDR_W = ADDR_W_DFLT
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  input  logic                frame_start,
  input  logic [COORD_W-1:0]  pos_x,
  input  logic [COORD_W-1:0]  pos_y,
  input  logic                pos_load,
  output logic                pos_ack,
  input  logic [SCROLL_W-1:0] scroll_step,
`ifdef SPRITE_MIRROR_EN
  input  logic                mirror,
`endif
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic                rom_data,
  output logic                pixel_valid,
  output logic                pixel_on,
  output logic [COORD_W-1:0]  pix_x,
  output logic [COORD_W-1:0]  pix_y
);

  pos_t              act_pos;
  scroll_t           scroll;
`ifdef SPRITE_MIRROR_EN
  logic              mirror_act;
`endif

  // Stage 0 signals
  coord_ext_t        x_ext, y_ext, ax_ext, ay_ext;
  logic              hit;
  coord_t            col, col_m, row;
  coord_ext_t        scol;
  logic [ADDR_W-1:0] addr_s0;

  // Pipeline registers
  logic              hit_d1, hit_d2, valid_d1;
  coord_t            x_d1, y_d1;

  sprite_pos_latch #(
    .SPR_W (SPR_W)
  ) u_pos_latch (
    .clk         (Clk),
    .rst         (Reset),
    .frame_start (frame_start),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .pos_load    (pos_load),
    .scroll_step (scroll_step),
`ifdef SPRITE_MIRROR_EN
    .mirror      (mirror),
    .mirror_act  (mirror_act),
`endif
    .pos_ack     (pos_ack),
    .act_pos     (act_pos),
    .scroll      (scroll)
  );

  // Stage 0: hit test on widened coordinates and ROM address formation.
  always_comb begin
    x_ext  = {1'b0, DrawX};
    y_ext  = {1'b0, DrawY};
    ax_ext = {1'b0, act_pos.x};
    ay_ext = {1'b0, act_pos.y};

    hit = (x_ext >= ax_ext) && (x_ext < ax_ext + coord_ext_t'(SPR_W)) &&
          (y_ext >= ay_ext) && (y_ext < ay_ext + coord_ext_t'(SPR_H));

    col = DrawX - act_pos.x;
    row = DrawY - act_pos.y;
`ifdef SPRITE_MIRROR_EN
    col_m = mirror_act ? (coord_t'(SPR_W - 1) - col) : col;
`else
    col_m = col;
`endif
    scol = wrap_once({1'b0, col_m} + coord_ext_t'(scroll), coord_ext_t'(SPR_W));

    // Parking the address at 0 off-sprite keeps the ROM input quiet.
    addr_s0 = '0;
    if (hit) begin
      addr_s0 = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(scol);
    end
  end

  // Stage 1: register ROM address, hit flag and coordinate.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
      x_d1     <= '0;
      y_d1     <= '0;
      valid_d1 <= 1'b0;
    end else begin
      rom_addr <= addr_s0;
      hit_d1   <= hit;
      x_d1     <= DrawX;
      y_d1     <= DrawY;
      valid_d1 <= 1'b1;
    end
  end

  // Stage 2: align hit flag and coordinate with the ROM's registered output.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_d2      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pixel_valid <= 1'b0;
    end else begin
      hit_d2      <= hit_d1;
      pix_x       <= x_d1;
      pix_y       <= y_d1;
      pixel_valid <= valid_d1;
    end
  end

  // rom_data is already the ROM's output register, so gating it here keeps
  // the 2-cycle latency without adding a third stage.
  assign pixel_on = hit_d2 & rom_data;

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
Read-side client of a 1-bit sprite ROM (135x40, 1-cycle registered read latency). It takes the VGA scan coordinate, hit-tests it against a frame-latched sprite position, and computes the ROM read address with horizontal scroll wrap. It realigns the returned ROM bit with a delayed valid/coordinate so the colour mapper sees a pixel-on flag. It sits between the VGA controller/game logic and one sprite ROM instance.

Parameters:
SPR_W, 135, sprite width in pixels
SPR_H, 40, sprite height in rows
ADDR_W, 13, ROM address width; must satisfy SPR_W*SPR_H <= 2**ADDR_W
COORD_W, 10, width of screen coordinates

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
DrawX  in  COORD_W  current scan column
DrawY  in  COORD_W  current scan row
frame_start  in  1  one-cycle pulse at start of vertical blank
pos_x  in  COORD_W  requested sprite left edge
pos_y  in  COORD_W  requested sprite top edge
pos_load  in  1  position update request
pos_ack  out  1  one-cycle acknowledge of pos_load
scroll_step  in  8  columns to advance the scroll per frame; must be < SPR_W
rom_addr  out  ADDR_W  ROM read address (registered)
rom_data  in  1  ROM data, valid 1 cycle after rom_addr
pixel_valid  out  1  pix_x/pix_y/pixel_on are valid
pixel_on  out  1  sprite bit at pix_x/pix_y; 0 outside sprite
pix_x  out  COORD_W  DrawX delayed 2 cycles
pix_y  out  COORD_W  DrawY delayed 2 cycles

Behaviour:
- Reset (async): active pos = 0,0; pending pos = 0,0; scroll = 0; FSM = IDLE; pos_ack, rom_addr, pixel_valid, pixel_on, pix_x, pix_y = 0.
- Hit test, stage 0, combinational: hit = (DrawX >= act_x) && (DrawX < act_x+SPR_W) && (DrawY >= act_y) && (DrawY < act_y+SPR_H). Sums are computed COORD_W+1 bits wide, with no overflow wrap.
- col = DrawX-act_x; row = DrawY-act_y; scol = col+scroll; if scol >= SPR_W then scol -= SPR_W (single conditional subtract).
- Address = row*SPR_W + scol, truncated to ADDR_W. When hit = 0, the address is held at 0.
- Stage 1 (registered): rom_addr, hit_d1, DrawX/Y_d1.
- Stage 2 (registered): pixel_valid = 1 every cycle after reset releases; pixel_on = hit_d2 & rom_data; pix_x/pix_y = DrawX/Y_d2.
- Total latency is 2 cycles, from DrawX/DrawY to pixel_on.
- Position handshake FSM, states IDLE and PENDING:
  - In IDLE, pos_load=1 latches pos_x/pos_y into pending, pulses pos_ack the next cycle, and moves to PENDING.
  - In PENDING, pos_load=1 overwrites pending and pulses pos_ack again (last write wins).
  - In PENDING, frame_start copies pending to active and returns to IDLE.
  - If pos_load and frame_start coincide (either state), the new values go to pending and the FSM ends in PENDING. Active takes the previously pending value if one existed; the new value waits for the next frame_start.
  - pos_ack is never high for two consecutive cycles unless pos_load is high on both preceding cycles.
- Scroll: on frame_start, scroll <= scroll+scroll_step, and if the result is >= SPR_W, SPR_W is subtracted. scroll is always in 0..SPR_W-1.
- Active position and scroll never change mid-frame (no tearing).
- Reset mid-frame clears the pipeline immediately. The first valid pixel appears 2 cycles after Reset falls.

Optional Feature:
SPRITE_MIRROR_EN
- Defined: adds input port mirror (1 bit, sampled and applied at frame_start like position). When the applied value is 1, col is replaced by SPR_W-1-col before the scroll add.
- Undefined: no mirror port, no mirror logic; the block behaves exactly as described above.

Decomposition:
- Package sprite_pkg: SPR_W/SPR_H defaults, ADDR_W, COORD_W, coord_t typedef, pos_t struct {x,y}, fsm enum {IDLE, PENDING}.
- One sub-module: sprite_pos_latch (handshake FSM, pending/active position registers, scroll counter, mirror register when enabled).
- Hit test, address math and pipeline stay in sprite_fetch.

Test Plan:
- Reset: active pos 0,0, scroll 0, DrawX=5, DrawY=2 -> rom_addr = 2*135+5 = 275 after 1 cycle; pixel_on equals mem[275] after 2 cycles.
- Bounds: pos=(100,50) applied; DrawX=99 or 235, or DrawY=90 -> pixel_on=0; DrawX=234, DrawY=89 -> rom_addr=39*135+134=5399.
- Scroll wrap: scroll_step=100, two frame_starts -> scroll=65. With pos=(0,0), DrawX=80, DrawY=0 -> rom_addr=10.
- Handshake: pos_load with (10,20) then (30,40) before frame_start -> two pos_ack pulses; active stays old until frame_start, then equals (30,40).
- Coincidence: pos_load(7,7) in the same cycle as frame_start with pending (1,1) -> active=(1,1), pending=(7,7), FSM=PENDING.
- Mid-operation reset: assert Reset during active scan -> all outputs 0 asynchronously; pipeline refills, pixel_valid=1 two cycles after release.
